// File: rtl/neo_tap_buffer.sv
// Multi-channel circular sample buffer emitting aligned NEO tap triples x[n-K], x[n], x[n+K].
// Optional NEO_ENERGY_EN adds a registered out_energy = cur*cur - prev*next output.
module neo_tap_buffer #(
  parameter int N  = 16,
  parameter int M  = 32,
  parameter int CH = 1,
  parameter int K  = 1,
  parameter int CW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          Clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_chan,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_chan,
  output logic [N-1:0]  out_prev,
  output logic [N-1:0]  out_cur,
  output logic [N-1:0]  out_next
`ifdef NEO_ENERGY_EN
  ,
  output logic signed [2*N:0] out_energy
`endif
);

  localparam int AW = $clog2(M);
  localparam int FW = $clog2(2*K+2);
  localparam logic [AW-1:0] LAG_1     = AW'(K);
  localparam logic [AW-1:0] LAG_2     = AW'(2*K);
  localparam logic [FW-1:0] FILL_MAX  = FW'(2*K+1);
  localparam logic [FW-1:0] FILL_TRIG = FW'(2*K);
  localparam logic [CW:0]   CH_LIM    = (CW+1)'(CH);

  logic [N-1:0]  mem_r  [CH][M];
  logic [AW-1:0] wptr_r [CH];
  logic [FW-1:0] fill_r [CH];

  logic          accept_s;
  logic          in_range_s;
  logic          load_s;
  logic [CW-1:0] chan_s;
  logic [AW-1:0] wptr_s;
  logic [AW-1:0] prev_addr_s;
  logic [AW-1:0] cur_addr_s;
  logic [FW-1:0] fill_s;
  logic [N-1:0]  prev_s;
  logic [N-1:0]  cur_s;

  // Handshake, channel decode and tap read-out for the sample being offered.
  always_comb begin
    in_ready   = !clear && (!out_valid || out_ready);
    accept_s   = in_valid && in_ready;
    in_range_s = ({1'b0, in_chan} < CH_LIM);
    if (in_range_s) begin
      chan_s = in_chan;
    end else begin
      chan_s = {CW{1'b0}};
    end
    wptr_s      = wptr_r[chan_s];
    fill_s      = fill_r[chan_s];
    // The write slot is wptr itself, so 2K < M keeps both taps clear of it.
    prev_addr_s = wptr_s - LAG_2;
    cur_addr_s  = wptr_s - LAG_1;
    prev_s      = mem_r[chan_s][prev_addr_s];
    cur_s       = mem_r[chan_s][cur_addr_s];
    load_s      = accept_s && in_range_s && (fill_s >= FILL_TRIG);
  end

`ifdef NEO_ENERGY_EN
  logic signed [2*N:0] prev_x_s;
  logic signed [2*N:0] cur_x_s;
  logic signed [2*N:0] next_x_s;
  logic signed [2*N:0] energy_s;

  // Full-precision Teager-Kaiser energy of the triple about to be loaded.
  always_comb begin
    prev_x_s = (2*N+1)'($signed(prev_s));
    cur_x_s  = (2*N+1)'($signed(cur_s));
    next_x_s = (2*N+1)'($signed(in_data));
    energy_s = (cur_x_s * cur_x_s) - (prev_x_s * next_x_s);
  end
`endif

  // Per-channel sample memory, write pointers and fill counters.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CH; c++) begin
        wptr_r[c] <= {AW{1'b0}};
        fill_r[c] <= {FW{1'b0}};
        for (int a = 0; a < M; a++) begin
          mem_r[c][a] <= {N{1'b0}};
        end
      end
    end else if (clear) begin
      for (int c = 0; c < CH; c++) begin
        wptr_r[c] <= {AW{1'b0}};
        fill_r[c] <= {FW{1'b0}};
      end
    end else if (accept_s && in_range_s) begin
      mem_r[chan_s][wptr_s] <= in_data;
      wptr_r[chan_s]        <= wptr_s + AW'(1);
      if (fill_s < FILL_MAX) begin
        fill_r[chan_s] <= fill_s + FW'(1);
      end
    end
  end

  // Output triple register with hold-while-stalled behaviour.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      out_chan   <= {CW{1'b0}};
      out_prev   <= {N{1'b0}};
      out_cur    <= {N{1'b0}};
      out_next   <= {N{1'b0}};
`ifdef NEO_ENERGY_EN
      out_energy <= {(2*N+1){1'b0}};
`endif
    end else if (clear) begin
      out_valid <= 1'b0;
    end else if (load_s) begin
      out_valid  <= 1'b1;
      out_chan   <= chan_s;
      out_prev   <= prev_s;
      out_cur    <= cur_s;
      out_next   <= in_data;
`ifdef NEO_ENERGY_EN
      out_energy <= energy_s;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_neo_tap_buffer.sv
// Self-checking bench for neo_tap_buffer: directed plan scenarios plus randomized traffic
// against a queue-based history model (out_energy checked when NEO_ENERGY_EN is defined).
module tb_neo_tap_buffer;

  localparam int N    = 16;
  localparam int M    = 4;
  localparam int CH   = 3;
  localparam int K    = 1;
  localparam int CW   = 2;
  localparam int TAPS = 2*K+1;

  logic          Clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_chan;
  logic [N-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_chan;
  logic [N-1:0]  out_prev;
  logic [N-1:0]  out_cur;
  logic [N-1:0]  out_next;
`ifdef NEO_ENERGY_EN
  logic [2*N:0]  out_energy;
`endif

  neo_tap_buffer #(.N(N), .M(M), .CH(CH), .K(K)) dut (
    .Clk       (Clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_chan   (in_chan),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chan  (out_chan),
    .out_prev  (out_prev),
    .out_cur   (out_cur),
    .out_next  (out_next)
`ifdef NEO_ENERGY_EN
    ,
    .out_energy(out_energy)
`endif
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] w16(input int d);
    logic [N-1:0] t;
    t = N'(d);
    return 64'(t);
  endfunction

  function automatic logic [63:0] w33(input longint d);
    logic [2*N:0] t;
    t = d[2*N:0];
    return 64'(t);
  endfunction

  // Reference model: last 2K+1 accepted samples per channel plus the expected output register.
  logic [N-1:0]  hist_q [CH][$];
  logic          m_valid;
  logic [CW-1:0] m_chan;
  logic [N-1:0]  m_prev, m_cur, m_next;
  longint        m_energy;

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) hist_q[c].delete();
    m_valid  = 1'b0;
    m_chan   = '0;
    m_prev   = '0;
    m_cur    = '0;
    m_next   = '0;
    m_energy = 0;
  endfunction

  task automatic cycle();
    logic exp_rdy;
    logic acc;
    longint p, c, x;
    @(negedge Clk);
    exp_rdy = !clear && (!m_valid || out_ready);
    check_val("in_ready", 64'(in_ready), 64'(exp_rdy));
    check_val("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      check_val("out_chan", 64'(out_chan), 64'(m_chan));
      check_val("out_prev", 64'(out_prev), 64'(m_prev));
      check_val("out_cur", 64'(out_cur), 64'(m_cur));
      check_val("out_next", 64'(out_next), 64'(m_next));
`ifdef NEO_ENERGY_EN
      check_val("out_energy", 64'(out_energy), w33(m_energy));
`endif
    end
    acc = in_valid && exp_rdy;
    @(posedge Clk);
    if (clear) begin
      for (int i = 0; i < CH; i++) hist_q[i].delete();
      m_valid = 1'b0;
    end else if (acc && (int'(in_chan) < CH)) begin
      hist_q[in_chan].push_back(in_data);
      if (hist_q[in_chan].size() > TAPS) void'(hist_q[in_chan].pop_front());
      if (hist_q[in_chan].size() == TAPS) begin
        m_prev  = hist_q[in_chan][0];
        m_cur   = hist_q[in_chan][K];
        m_next  = hist_q[in_chan][2*K];
        m_chan  = in_chan;
        m_valid = 1'b1;
        p = longint'($signed(m_prev));
        c = longint'($signed(m_cur));
        x = longint'($signed(m_next));
        m_energy = c*c - p*x;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic send(input int ch, input int d, input logic v, input logic rdy);
    in_chan   = CW'(ch);
    in_data   = N'(d);
    in_valid  = v;
    out_ready = rdy;
    cycle();
  endtask

  task automatic expect_triple(input string tag, input int ch, input int p, input int c, input int x);
    check_val({tag, "_valid"}, 64'(out_valid), 64'(1));
    check_val({tag, "_chan"}, 64'(out_chan), w16(ch));
    check_val({tag, "_prev"}, 64'(out_prev), w16(p));
    check_val({tag, "_cur"}, 64'(out_cur), w16(c));
    check_val({tag, "_next"}, 64'(out_next), w16(x));
  endtask

  task automatic expect_zero_outputs(input string tag);
    check_val({tag, "_valid"}, 64'(out_valid), 64'(0));
    check_val({tag, "_chan"}, 64'(out_chan), 64'(0));
    check_val({tag, "_prev"}, 64'(out_prev), 64'(0));
    check_val({tag, "_cur"}, 64'(out_cur), 64'(0));
    check_val({tag, "_next"}, 64'(out_next), 64'(0));
  endtask

  initial begin
    reset     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_chan   = '0;
    in_data   = '0;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    expect_zero_outputs("reset");
    reset = 1'b1;

    // Basic triple formation and energy values.
    send(0, 3, 1'b1, 1'b1);
    send(0, 5, 1'b1, 1'b1);
    check_val("t1_no_valid", 64'(out_valid), 64'(0));
    send(0, 2, 1'b1, 1'b1);
    expect_triple("t1", 0, 3, 5, 2);
`ifdef NEO_ENERGY_EN
    check_val("t1_energy", 64'(out_energy), w33(19));
`endif
    send(0, 7, 1'b1, 1'b1);
    expect_triple("t2a", 0, 5, 2, 7);
`ifdef NEO_ENERGY_EN
    check_val("t2a_energy", 64'(out_energy), w33(-31));
`endif
    send(0, -4, 1'b1, 1'b1);
    expect_triple("t2b", 0, 2, 7, -4);
`ifdef NEO_ENERGY_EN
    check_val("t2b_energy", 64'(out_energy), w33(57));
`endif

    // Clear with a concurrent sample, then a fresh stream across the pointer wrap.
    clear = 1'b1;
    send(0, 99, 1'b1, 1'b1);
    clear = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      send(0, k, 1'b1, 1'b1);
      if (k >= 3) expect_triple("t3", 0, k-2, k-1, k);
      else check_val("t3_fresh", 64'(out_valid), 64'(0));
    end

    // Channel interleave with an out-of-range tag mixed in.
    clear = 1'b1;
    send(0, 0, 1'b0, 1'b1);
    clear = 1'b0;
    send(0, 10, 1'b1, 1'b1);
    send(1, -1, 1'b1, 1'b1);
    send(3, 555, 1'b1, 1'b1);
    send(0, 20, 1'b1, 1'b1);
    send(1, -2, 1'b1, 1'b1);
    send(0, 30, 1'b1, 1'b1);
    expect_triple("t4_ch0", 0, 10, 20, 30);
    send(1, -3, 1'b1, 1'b1);
    expect_triple("t4_ch1", 1, -1, -2, -3);

    // Stall: outputs hold and input is refused, then released.
    for (int i = 0; i < 5; i++) begin
      send(0, 40, 1'b1, 1'b0);
      expect_triple("t5_hold", 1, -1, -2, -3);
    end
    send(0, 40, 1'b1, 1'b1);
    expect_triple("t5_release", 0, 20, 30, 40);

    // Asynchronous reset in the middle of a cycle.
    send(0, 50, 1'b1, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    expect_zero_outputs("t6_reset");
    check_val("t6_reset_rdy", 64'(in_ready), 64'(1));
    model_reset();
    in_valid = 1'b0;
    repeat (2) @(posedge Clk);
    #3;
    reset = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      clear = ($urandom_range(0, 49) == 0);
      send(int'($urandom_range(0, 3)), int'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7);
    end
    clear = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
